// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator controller: FSM states,
// operator encodings and the largest legal decimal digit.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A    = 3'd0,
    ENTER_B    = 3'd1,
    EXEC       = 3'd2,
    CLEAR_WAIT = 3'd3,
    RESULT     = 3'd4,
    ERROR      = 3'd5
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/digit_accumulator.sv
// Decimal operand builder: acc <= acc*10 + d with a cap on significant digits.
// Exposes the next-state value so the parent can register a matching display.
module digit_accumulator
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic signed [WIDTH-1:0] load_val_i,
  input  logic                    dig_strobe_i,
  input  logic [3:0]              dig_code_i,
  output logic signed [WIDTH-1:0] acc_o,
  output logic signed [WIDTH-1:0] acc_d_o,
  output logic [CNT_W-1:0]        count_o,
  output logic                    entered_o,
  output logic                    entered_d_o
);

  logic signed [WIDTH-1:0] acc_q, acc_d, base_acc, dig_ext;
  logic [CNT_W-1:0]        cnt_q, cnt_d, base_cnt;
  logic                    ent_q, ent_d;

  // Clear and digit may coincide: the digit then lands on a zeroed operand.
  always_comb begin
    base_acc = clear_i ? '0 : acc_q;
    base_cnt = clear_i ? '0 : cnt_q;
    dig_ext  = {{(WIDTH-4){1'b0}}, dig_code_i};
    acc_d    = base_acc;
    cnt_d    = base_cnt;
    ent_d    = clear_i ? 1'b0 : ent_q;
    if (load_i) begin
      acc_d = load_val_i;
      cnt_d = '0;
      ent_d = 1'b1;
    end else if (dig_strobe_i && (dig_code_i <= DIGIT_MAX)) begin
      ent_d = 1'b1;
      if (base_cnt != CNT_W'(MAX_DIGITS)) begin
        acc_d = (base_acc <<< 3) + (base_acc <<< 1) + dig_ext;
        if (!((base_acc == '0) && (dig_code_i == 4'd0))) cnt_d = base_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ent_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

  assign acc_o       = acc_q;
  assign acc_d_o     = acc_d;
  assign count_o     = cnt_q;
  assign entered_o   = ent_q;
  assign entered_d_o = ent_d;

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencing FSM: builds operands A and B from keypad strobes,
// launches one ALU operation per execute, and drives display and error.
module calc_controller #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dig_strobe,
  input  logic                    reset_strobe,
  input  logic                    ex_strobe,
  input  logic                    op_strobe,
  input  logic [3:0]              dig_code,
  input  logic [1:0]              op_code,
  input  logic                    alu_done,
  input  logic signed [WIDTH-1:0] alu_result,
  input  logic                    alu_error,
  output logic                    alu_start,
  output logic signed [WIDTH-1:0] operand_a,
  output logic signed [WIDTH-1:0] operand_b,
  output logic [1:0]              alu_op,
  output logic signed [WIDTH-1:0] display_val,
  output logic                    err
);
  import calc_pkg::*;

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic                    start_q, start_d, err_q, err_d;
  logic signed [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, disp_q, disp_d;

  logic                    clr_a, clr_b, ld_a, dig_a, dig_b, do_clear;
  logic signed [WIDTH-1:0] a_acc, a_next, b_acc, b_next;
  logic [CNT_W-1:0]        a_cnt, b_cnt;
  logic                    a_ent, a_ent_next, b_ent, b_ent_next;

  digit_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk(clk), .reset_n(reset_n), .clear_i(clr_a), .load_i(ld_a),
    .load_val_i(alu_result), .dig_strobe_i(dig_a), .dig_code_i(dig_code),
    .acc_o(a_acc), .acc_d_o(a_next), .count_o(a_cnt),
    .entered_o(a_ent), .entered_d_o(a_ent_next)
  );

  digit_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk(clk), .reset_n(reset_n), .clear_i(clr_b), .load_i(1'b0),
    .load_val_i('0), .dig_strobe_i(dig_b), .dig_code_i(dig_code),
    .acc_o(b_acc), .acc_d_o(b_next), .count_o(b_cnt),
    .entered_o(b_ent), .entered_d_o(b_ent_next)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    start_d  = 1'b0;
    opa_d    = opa_q;
    opb_d    = opb_q;
    clr_a    = 1'b0;
    clr_b    = 1'b0;
    ld_a     = 1'b0;
    dig_a    = 1'b0;
    dig_b    = 1'b0;
    do_clear = 1'b0;
    case (state_q)
      ENTER_A: begin
        if (reset_strobe) do_clear = 1'b1;
        else if (dig_strobe) dig_a = 1'b1;
        else if (op_strobe) begin
          op_d    = op_code;
          clr_b   = 1'b1;
          state_d = ENTER_B;
        end
      end
      ENTER_B: begin
        if (reset_strobe) do_clear = 1'b1;
        else if (dig_strobe) dig_b = 1'b1;
        else if (op_strobe && !b_ent) op_d = op_code;
        else if (ex_strobe && b_ent) begin
          start_d = 1'b1;
          opa_d   = a_acc;
          opb_d   = b_acc;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // A clear coinciding with alu_done has nothing left to wait for.
        if (reset_strobe) begin
          if (alu_done) do_clear = 1'b1;
          else          state_d  = CLEAR_WAIT;
        end else if (alu_done) begin
          if (alu_error) state_d = ERROR;
          else begin
            ld_a    = 1'b1;
            state_d = RESULT;
          end
        end
      end
      CLEAR_WAIT: begin
        if (reset_strobe || alu_done) do_clear = 1'b1;
      end
      RESULT: begin
        if (reset_strobe) do_clear = 1'b1;
        else if (dig_strobe) begin
          clr_a   = 1'b1;
          dig_a   = 1'b1;
          state_d = ENTER_A;
        end else if (op_strobe) begin
          op_d    = op_code;
          clr_b   = 1'b1;
          state_d = ENTER_B;
        end
      end
      ERROR: begin
        if (reset_strobe) do_clear = 1'b1;
      end
      default: do_clear = 1'b1;
    endcase

    if (do_clear) begin
      clr_a   = 1'b1;
      clr_b   = 1'b1;
      op_d    = OP_ADD;
      state_d = ENTER_A;
    end
  end

  // Display is derived from the next state so it updates on the same edge.
  always_comb begin
    disp_d = disp_q;
    case (state_d)
      ENTER_A: disp_d = a_next;
      ENTER_B: disp_d = b_ent_next ? b_next : a_next;
      RESULT:  disp_d = a_next;
      ERROR:   disp_d = '0;
      default: disp_d = disp_q;
    endcase
    err_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ENTER_A;
      op_q    <= OP_ADD;
      start_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      start_q <= start_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
    end
  end

  assign alu_start   = start_q;
  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign alu_op      = op_q;
  assign display_val = disp_q;
  assign err         = err_q;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: a vector table of keypad/ALU events
// with hand-computed expectations, plus async-reset sequences.
module tb_calc_controller;
  import calc_pkg::*;

  localparam logic [2:0] K_DIG = 3'd0, K_OP = 3'd1, K_EX = 3'd2,
                         K_CLR = 3'd3, K_DONE = 3'd4, K_IDLE = 3'd5;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] val;
    logic        aerr;
    state_e      e_state;
    logic [15:0] e_disp;
    logic        e_err;
    logic        e_start;
    logic [1:0]  e_op;
    logic        co;
    logic [15:0] e_opa;
    logic [15:0] e_opb;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               dig_strobe = 1'b0, reset_strobe = 1'b0;
  logic               ex_strobe = 1'b0, op_strobe = 1'b0;
  logic [3:0]         dig_code = '0;
  logic [1:0]         op_code = '0;
  logic               alu_done = 1'b0, alu_error = 1'b0;
  logic signed [15:0] alu_result = '0;
  logic               alu_start, err;
  logic signed [15:0] operand_a, operand_b, display_val;
  logic [1:0]         alu_op;

  int   checks = 0;
  int   errors = 0;
  vec_t vt[$];

  calc_controller #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .dig_strobe(dig_strobe), .reset_strobe(reset_strobe),
    .ex_strobe(ex_strobe), .op_strobe(op_strobe),
    .dig_code(dig_code), .op_code(op_code),
    .alu_done(alu_done), .alu_result(alu_result), .alu_error(alu_error),
    .alu_start(alu_start), .operand_a(operand_a), .operand_b(operand_b),
    .alu_op(alu_op), .display_val(display_val), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] k, input logic [15:0] v, input logic ae,
                     input state_e st, input logic [15:0] disp, input logic er,
                     input logic start, input logic [1:0] op, input logic co,
                     input logic [15:0] opa, input logic [15:0] opb);
    vec_t r;
    r.kind = k; r.val = v; r.aerr = ae; r.e_state = st; r.e_disp = disp;
    r.e_err = er; r.e_start = start; r.e_op = op; r.co = co;
    r.e_opa = opa; r.e_opb = opb;
    vt.push_back(r);
  endtask

  task automatic apply(input logic [2:0] k, input logic [15:0] v, input logic ae);
    case (k)
      K_DIG:  begin dig_strobe = 1'b1; dig_code = v[3:0]; end
      K_OP:   begin op_strobe = 1'b1; op_code = v[1:0]; end
      K_EX:   ex_strobe = 1'b1;
      K_CLR:  reset_strobe = 1'b1;
      K_DONE: begin alu_done = 1'b1; alu_result = v; alu_error = ae; end
      default: ;
    endcase
    @(posedge clk);
    #1;
    dig_strobe = 1'b0; op_strobe = 1'b0; ex_strobe = 1'b0;
    reset_strobe = 1'b0; alu_done = 1'b0; alu_error = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 32'(alu_start), 0);
    chk({tag, "_opa"}, 32'(operand_a), 0);
    chk({tag, "_opb"}, 32'(operand_b), 0);
    chk({tag, "_op"}, 32'(alu_op), 0);
    chk({tag, "_disp"}, 32'(display_val), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    // 12 + 34 = 46, then chain *2 = 92
    add(K_DIG, 1, 0, ENTER_A, 1, 0, 0, 0, 0, 0, 0);
    add(K_DIG, 2, 0, ENTER_A, 12, 0, 0, 0, 0, 0, 0);
    add(K_OP, 0, 0, ENTER_B, 12, 0, 0, 0, 0, 0, 0);
    add(K_DIG, 3, 0, ENTER_B, 3, 0, 0, 0, 0, 0, 0);
    add(K_DIG, 4, 0, ENTER_B, 34, 0, 0, 0, 0, 0, 0);
    add(K_EX, 0, 0, EXEC, 34, 0, 1, 0, 1, 12, 34);
    add(K_IDLE, 0, 0, EXEC, 34, 0, 0, 0, 1, 12, 34);
    add(K_DONE, 46, 0, RESULT, 46, 0, 0, 0, 0, 0, 0);
    add(K_OP, 2, 0, ENTER_B, 46, 0, 0, 2, 0, 0, 0);
    add(K_DIG, 2, 0, ENTER_B, 2, 0, 0, 2, 0, 0, 0);
    add(K_EX, 0, 0, EXEC, 2, 0, 1, 2, 1, 46, 2);
    add(K_DONE, 92, 0, RESULT, 92, 0, 0, 2, 0, 0, 0);
    // digit limit and leading zeros
    add(K_DIG, 1, 0, ENTER_A, 1, 0, 0, 2, 0, 0, 0);
    add(K_DIG, 2, 0, ENTER_A, 12, 0, 0, 2, 0, 0, 0);
    add(K_DIG, 3, 0, ENTER_A, 123, 0, 0, 2, 0, 0, 0);
    add(K_DIG, 4, 0, ENTER_A, 1234, 0, 0, 2, 0, 0, 0);
    add(K_DIG, 5, 0, ENTER_A, 1234, 0, 0, 2, 0, 0, 0);
    add(K_CLR, 0, 0, ENTER_A, 0, 0, 0, 0, 0, 0, 0);
    add(K_DIG, 0, 0, ENTER_A, 0, 0, 0, 0, 0, 0, 0);
    add(K_DIG, 0, 0, ENTER_A, 0, 0, 0, 0, 0, 0, 0);
    add(K_DIG, 7, 0, ENTER_A, 7, 0, 0, 0, 0, 0, 0);
    // operator replacement, execute without B
    add(K_EX, 0, 0, ENTER_A, 7, 0, 0, 0, 0, 0, 0);
    add(K_OP, 0, 0, ENTER_B, 7, 0, 0, 0, 0, 0, 0);
    add(K_OP, 1, 0, ENTER_B, 7, 0, 0, 1, 0, 0, 0);
    add(K_EX, 0, 0, ENTER_B, 7, 0, 0, 1, 0, 0, 0);
    add(K_DIG, 0, 0, ENTER_B, 0, 0, 0, 1, 0, 0, 0);
    add(K_OP, 2, 0, ENTER_B, 0, 0, 0, 1, 0, 0, 0);
    add(K_EX, 0, 0, EXEC, 0, 0, 1, 1, 1, 7, 0);
    add(K_DONE, 7, 0, RESULT, 7, 0, 0, 1, 0, 0, 0);
    // divide by zero -> ERROR, only clear exits
    add(K_OP, 3, 0, ENTER_B, 7, 0, 0, 3, 0, 0, 0);
    add(K_DIG, 0, 0, ENTER_B, 0, 0, 0, 3, 0, 0, 0);
    add(K_EX, 0, 0, EXEC, 0, 0, 1, 3, 1, 7, 0);
    add(K_DONE, 16'h1234, 1, ERROR, 0, 1, 0, 3, 0, 0, 0);
    add(K_DIG, 5, 0, ERROR, 0, 1, 0, 3, 0, 0, 0);
    add(K_EX, 0, 0, ERROR, 0, 1, 0, 3, 0, 0, 0);
    add(K_OP, 0, 0, ERROR, 0, 1, 0, 3, 0, 0, 0);
    add(K_CLR, 0, 0, ENTER_A, 0, 0, 0, 0, 0, 0, 0);
    // clear during EXEC
    add(K_DIG, 9, 0, ENTER_A, 9, 0, 0, 0, 0, 0, 0);
    add(K_OP, 0, 0, ENTER_B, 9, 0, 0, 0, 0, 0, 0);
    add(K_DIG, 1, 0, ENTER_B, 1, 0, 0, 0, 0, 0, 0);
    add(K_EX, 0, 0, EXEC, 1, 0, 1, 0, 1, 9, 1);
    add(K_CLR, 0, 0, CLEAR_WAIT, 1, 0, 0, 0, 1, 9, 1);
    add(K_IDLE, 0, 0, CLEAR_WAIT, 1, 0, 0, 0, 0, 0, 0);
    add(K_DONE, 99, 0, ENTER_A, 0, 0, 0, 0, 0, 0, 0);
    add(K_IDLE, 0, 0, ENTER_A, 0, 0, 0, 0, 0, 0, 0);

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_state", 32'(dut.state_q), 32'(ENTER_A));
    reset_n = 1'b1;

    foreach (vt[i]) begin
      apply(vt[i].kind, vt[i].val, vt[i].aerr);
      chk($sformatf("v%0d_state", i), 32'(dut.state_q), 32'(vt[i].e_state));
      chk($sformatf("v%0d_disp", i), 32'(display_val), 32'(vt[i].e_disp));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_start", i), 32'(alu_start), 32'(vt[i].e_start));
      chk($sformatf("v%0d_op", i), 32'(alu_op), 32'(vt[i].e_op));
      if (vt[i].co) begin
        chk($sformatf("v%0d_opa", i), 32'(operand_a), 32'(vt[i].e_opa));
        chk($sformatf("v%0d_opb", i), 32'(operand_b), 32'(vt[i].e_opb));
      end
    end

    // async reset mid-entry clears outputs without a clock edge
    apply(K_DIG, 5, 0);
    apply(K_DIG, 6, 0);
    chk("mid_disp", 32'(display_val), 56);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_entry");
    #2 reset_n = 1'b1;

    // async reset mid-EXEC, late alu_done ignored in ENTER_A
    apply(K_DIG, 1, 0);
    apply(K_OP, 0, 0);
    apply(K_DIG, 1, 0);
    apply(K_EX, 0, 0);
    chk("exec_start", 32'(alu_start), 1);
    chk("exec_state", 32'(dut.state_q), 32'(EXEC));
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_exec");
    #2 reset_n = 1'b1;
    apply(K_DONE, 2, 0);
    chk("late_state", 32'(dut.state_q), 32'(ENTER_A));
    chk("late_disp", 32'(display_val), 0);
    chk("late_err", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
